// File: rtl/lpc_pkg.sv
// -----------------------------------------------------------------------------
// lpc_pkg
// Shared constants, FSM state type and the output saturation helper for the
// LPC all-pole synthesis filter (lpc_synth) and its multiply-accumulate
// datapath (lpc_mac).
//
// Contents:
//   ORDER, QF, ACC_W      filter order, coefficient fraction bits, accumulator width
//   DATA_W, PROD_W        sample/coefficient width and full product width
//   CNT_W                 tap counter width (holds 0..ORDER)
//   ROUND_C               half-LSB rounding constant added before the >>> QF
//   SAT_MAX / SAT_MIN     output sample limits
//   state_t               IDLE / MAC / OUT
//   sat_sample()          clamp an accumulator-width value to a 16-bit sample
// -----------------------------------------------------------------------------
package lpc_pkg;

    localparam int ORDER  = 10;
    localparam int QF     = 15;
    localparam int ACC_W  = 40;
    localparam int DATA_W = 16;
    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(ORDER + 1);

    localparam logic signed [ACC_W-1:0]  ROUND_C     = 40'sh0000004000;
    localparam logic signed [DATA_W-1:0] SAT_MAX     = 16'sh7FFF;
    localparam logic signed [DATA_W-1:0] SAT_MIN     = 16'sh8000;
    localparam logic signed [ACC_W-1:0]  SAT_MAX_ACC = 40'sh0000007FFF;
    localparam logic signed [ACC_W-1:0]  SAT_MIN_ACC = 40'shFFFFFF8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    // Clamp a value that has already been scaled back to sample units.
    function automatic logic signed [DATA_W-1:0] sat_sample(
        input logic signed [ACC_W-1:0] v
    );
        logic signed [DATA_W-1:0] res;
        if (v > SAT_MAX_ACC) begin
            res = SAT_MAX;
        end else if (v < SAT_MIN_ACC) begin
            res = SAT_MIN;
        end else begin
            res = v[DATA_W-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/lpc_mac.sv
// -----------------------------------------------------------------------------
// lpc_mac
// Combinational multiply-subtract step of the synthesis filter:
//   acc_out = acc_in - coef * sample
// The 16x16 product is kept at its full 32-bit signed width and then
// sign-extended to the accumulator width, so no intermediate ever wraps.
//
// Ports:
//   acc_in   in   ACC_W   running accumulator (signed)
//   coef     in   DATA_W  Q15 predictor coefficient a_i (signed)
//   sample   in   DATA_W  past output sample y[n-i] (signed)
//   acc_out  out  ACC_W   updated accumulator (signed)
// -----------------------------------------------------------------------------
module lpc_mac
    import lpc_pkg::*;
(
    input  logic signed [ACC_W-1:0]  acc_in,
    input  logic signed [DATA_W-1:0] coef,
    input  logic signed [DATA_W-1:0] sample,
    output logic signed [ACC_W-1:0]  acc_out
);

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;

    assign prod     = coef * sample;
    assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
    assign acc_out  = acc_in - prod_ext;

endmodule

// File: rtl/lpc_synth.sv
// -----------------------------------------------------------------------------
// lpc_synth
// All-pole LPC synthesis filter  y[n] = e[n] - sum(i=1..10) a_i * y[n-i],
// evaluated serially with one shared multiply-subtract unit: one cycle to
// accept a residual sample, ten MAC cycles (one per tap), one cycle to round,
// saturate and publish the result. A new sample can be accepted every 12
// cycles.
//
// Coefficient updates arriving while a sample is in flight are parked in a
// shadow bank and take effect when the filter returns to IDLE, so a sample
// is always filtered with one consistent coefficient set.
//
// Ports:
//   clk              in   1   clock, rising edge
//   rst              in   1   synchronous reset, active low
//   a_in1..a_in10    in   16  signed Q15 coefficients
//   a_v              in   1   coefficient strobe
//   e_in             in   16  signed residual sample
//   e_v              in   1   residual sample valid
//   e_rdy            out  1   ready for a residual sample (IDLE only)
//   y_out            out  16  signed synthesized sample (held between strobes)
//   y_v              out  1   one-cycle strobe for y_out
// -----------------------------------------------------------------------------
module lpc_synth
    import lpc_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] a_in1,
    input  logic signed [DATA_W-1:0] a_in2,
    input  logic signed [DATA_W-1:0] a_in3,
    input  logic signed [DATA_W-1:0] a_in4,
    input  logic signed [DATA_W-1:0] a_in5,
    input  logic signed [DATA_W-1:0] a_in6,
    input  logic signed [DATA_W-1:0] a_in7,
    input  logic signed [DATA_W-1:0] a_in8,
    input  logic signed [DATA_W-1:0] a_in9,
    input  logic signed [DATA_W-1:0] a_in10,
    input  logic                     a_v,
    input  logic signed [DATA_W-1:0] e_in,
    input  logic                     e_v,
    output logic                     e_rdy,
    output logic signed [DATA_W-1:0] y_out,
    output logic                     y_v
);

    state_t                    state;
    logic signed [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]          tap_cnt;
    logic                      pending;

    logic signed [DATA_W-1:0]  a_bus       [1:ORDER];
    logic signed [DATA_W-1:0]  work_bank   [1:ORDER];
    logic signed [DATA_W-1:0]  shadow_bank [1:ORDER];
    logic signed [DATA_W-1:0]  y_hist      [1:ORDER];

    logic signed [DATA_W-1:0]  cur_coef;
    logic signed [DATA_W-1:0]  cur_sample;
    logic signed [ACC_W-1:0]   mac_out;
    logic signed [ACC_W-1:0]   e_ext;
    logic signed [ACC_W-1:0]   acc_init;
    logic signed [ACC_W-1:0]   acc_scaled;
    logic signed [DATA_W-1:0]  y_sat;

    assign a_bus[1]  = a_in1;
    assign a_bus[2]  = a_in2;
    assign a_bus[3]  = a_in3;
    assign a_bus[4]  = a_in4;
    assign a_bus[5]  = a_in5;
    assign a_bus[6]  = a_in6;
    assign a_bus[7]  = a_in7;
    assign a_bus[8]  = a_in8;
    assign a_bus[9]  = a_in9;
    assign a_bus[10] = a_in10;

    // Ready is a pure decode of IDLE, gated by reset so it drops immediately
    // while reset is held and rises as soon as reset is released.
    assign e_rdy = rst && (state == IDLE);

    // Accumulator seed: residual moved into Q15 plus half an LSB, so the
    // final arithmetic shift rounds half-up instead of truncating.
    assign e_ext    = {{(ACC_W - DATA_W){e_in[DATA_W-1]}}, e_in};
    assign acc_init = (e_ext <<< QF) + ROUND_C;

    // Tap select: the counter picks a_i and y[n-i]; counter value 0 (outside
    // the MAC phase) selects nothing.
    always_comb begin
        cur_coef   = '0;
        cur_sample = '0;
        for (int i = 1; i <= ORDER; i++) begin
            if (tap_cnt == CNT_W'(i)) begin
                cur_coef   = work_bank[i];
                cur_sample = y_hist[i];
            end
        end
    end

    lpc_mac u_mac (
        .acc_in  (acc),
        .coef    (cur_coef),
        .sample  (cur_sample),
        .acc_out (mac_out)
    );

    assign acc_scaled = acc >>> QF;
    assign y_sat      = sat_sample(acc_scaled);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            acc     <= '0;
            tap_cnt <= '0;
            pending <= 1'b0;
            y_out   <= '0;
            y_v     <= 1'b0;
            for (int i = 1; i <= ORDER; i++) begin
                work_bank[i]   <= '0;
                shadow_bank[i] <= '0;
                y_hist[i]      <= '0;
            end
        end else begin
            y_v <= 1'b0;
            case (state)
                IDLE: begin
                    // Loading on the accept edge means the accepted sample
                    // already sees the new bank in its first MAC cycle.
                    if (a_v) begin
                        for (int i = 1; i <= ORDER; i++) begin
                            work_bank[i] <= a_bus[i];
                        end
                    end
                    if (e_v && e_rdy) begin
                        acc     <= acc_init;
                        tap_cnt <= CNT_W'(1);
                        state   <= MAC;
                    end
                end

                MAC: begin
                    if (a_v) begin
                        for (int i = 1; i <= ORDER; i++) begin
                            shadow_bank[i] <= a_bus[i];
                        end
                        pending <= 1'b1;
                    end
                    acc <= mac_out;
                    if (tap_cnt == CNT_W'(ORDER)) begin
                        tap_cnt <= '0;
                        state   <= OUT;
                    end else begin
                        tap_cnt <= tap_cnt + 1'b1;
                    end
                end

                OUT: begin
                    y_out     <= y_sat;
                    y_v       <= 1'b1;
                    y_hist[1] <= y_sat;
                    for (int i = 2; i <= ORDER; i++) begin
                        y_hist[i] <= y_hist[i-1];
                    end
                    // A strobe on this very edge is newer than anything in
                    // the shadow bank, so it goes straight to the working bank.
                    if (a_v) begin
                        for (int i = 1; i <= ORDER; i++) begin
                            work_bank[i]   <= a_bus[i];
                            shadow_bank[i] <= a_bus[i];
                        end
                    end else if (pending) begin
                        for (int i = 1; i <= ORDER; i++) begin
                            work_bank[i] <= shadow_bank[i];
                        end
                    end
                    pending <= 1'b0;
                    tap_cnt <= '0;
                    state   <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lpc_synth.sv
// -----------------------------------------------------------------------------
// tb_lpc_synth
// Self-checking bench for lpc_synth. Every accepted residual sample pushes the
// output predicted by a reference model of the synthesis equation onto a
// scoreboard queue; a monitor on the falling edge pops and compares on every
// y_v strobe, checks the strobe latency, the ready handshake while busy and
// that y_out holds between strobes.
// -----------------------------------------------------------------------------
module tb_lpc_synth;

    localparam int TAPS = 10;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic signed [15:0] coef_drive [1:TAPS];
    logic               a_v  = 1'b0;
    logic signed [15:0] e_in = '0;
    logic               e_v  = 1'b0;
    logic               e_rdy;
    logic signed [15:0] y_out;
    logic               y_v;

    typedef struct {
        int y;
        int acc_cyc;
    } exp_t;

    exp_t exp_q[$];

    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;

    int  model_work [1:TAPS];
    int  model_pend [1:TAPS];
    int  model_hist [1:TAPS];
    bit  pend_flag  = 1'b0;
    int  last_y     = 0;
    bit  in_reset   = 1'b1;
    bit  have_acc   = 1'b0;
    int  acc_last   = 0;

    lpc_synth dut (
        .clk    (clk),
        .rst    (rst),
        .a_in1  (coef_drive[1]),
        .a_in2  (coef_drive[2]),
        .a_in3  (coef_drive[3]),
        .a_in4  (coef_drive[4]),
        .a_in5  (coef_drive[5]),
        .a_in6  (coef_drive[6]),
        .a_in7  (coef_drive[7]),
        .a_in8  (coef_drive[8]),
        .a_in9  (coef_drive[9]),
        .a_in10 (coef_drive[10]),
        .a_v    (a_v),
        .e_in   (e_in),
        .e_v    (e_v),
        .e_rdy  (e_rdy),
        .y_out  (y_out),
        .y_v    (y_v)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Reference synthesis step in plain integer arithmetic.
    function automatic int model_step(input int e);
        longint acc;
        longint r;
        acc = longint'(e) * 32768 + 16384;
        for (int i = 1; i <= TAPS; i++) begin
            acc = acc - longint'(model_work[i]) * longint'(model_hist[i]);
        end
        r = acc >>> 15;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        for (int i = TAPS; i >= 2; i--) begin
            model_hist[i] = model_hist[i-1];
        end
        model_hist[1] = int'(r);
        return int'(r);
    endfunction

    task automatic set_drive(input int c1, input int rest);
        coef_drive[1] = 16'(c1);
        for (int i = 2; i <= TAPS; i++) coef_drive[i] = 16'(rest);
    endtask

    task automatic model_clear();
        for (int i = 1; i <= TAPS; i++) begin
            model_work[i] = 0;
            model_pend[i] = 0;
            model_hist[i] = 0;
        end
        pend_flag = 1'b0;
        last_y    = 0;
        exp_q.delete();
        have_acc  = 1'b0;
    endtask

    // Coefficient load while the filter is idle.
    task automatic load_coefs();
        @(negedge clk);
        a_v = 1'b1;
        @(posedge clk);
        #1;
        a_v = 1'b0;
        for (int i = 1; i <= TAPS; i++) model_work[i] = int'(coef_drive[i]);
        pend_flag = 1'b0;
    endtask

    // Coefficient strobe issued while a sample is in flight.
    task automatic pulse_busy_coefs();
        a_v = 1'b1;
        for (int i = 1; i <= TAPS; i++) model_pend[i] = int'(coef_drive[i]);
        pend_flag = 1'b1;
        @(negedge clk);
        a_v = 1'b0;
    endtask

    // Offer one residual sample; returns just after the accepting edge.
    task automatic apply_stimulus(input int e, input bit hold, input bit with_av);
        int waited;
        int y;
        waited = 0;
        @(negedge clk);
        e_in = 16'(e);
        e_v  = 1'b1;
        if (with_av) a_v = 1'b1;
        while (!e_rdy && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (!e_rdy) begin
            check_output("e_rdy_timeout", 0, 1);
            e_v = 1'b0;
            a_v = 1'b0;
            return;
        end
        if (a_v) begin
            for (int i = 1; i <= TAPS; i++) model_work[i] = int'(coef_drive[i]);
            pend_flag = 1'b0;
        end else if (pend_flag) begin
            for (int i = 1; i <= TAPS; i++) model_work[i] = model_pend[i];
            pend_flag = 1'b0;
        end
        y = model_step(e);
        @(posedge clk);
        #1;
        exp_q.push_back('{y: y, acc_cyc: cyc});
        acc_last = cyc;
        have_acc = 1'b1;
        a_v = 1'b0;
        if (!hold) e_v = 1'b0;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && e_rdy) && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0 || !e_rdy) check_output("idle_timeout", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        in_reset = 1'b1;
        rst      = 1'b0;
        e_v      = 1'b0;
        a_v      = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_y_v", y_v, 0);
        check_output("rst_y_out", y_out, 0);
        check_output("rst_e_rdy", e_rdy, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("e_rdy_after_reset", e_rdy, 1);
        in_reset = 1'b0;
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        exp_t x;
        int   d;
        if (!in_reset) begin
            if (y_v) begin
                if (exp_q.size() == 0) begin
                    check_output("y_v_unexpected", 1, 0);
                end else begin
                    x = exp_q.pop_front();
                    check_output("y_out", y_out, x.y);
                    // Counted up to the edge on which the strobe is captured.
                    check_output("y_v_edges", cyc - x.acc_cyc + 1, 12);
                    last_y = x.y;
                end
            end else begin
                check_output("y_out_hold", y_out, last_y);
            end
            if (have_acc) begin
                d = cyc - acc_last;
                if (d <= 10)      check_output("e_rdy_busy", e_rdy, 0);
                else if (d == 11) check_output("e_rdy_with_y_v", e_rdy, 1);
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int prev_acc;
        set_drive(0, 0);
        model_clear();

        // Power-up reset
        repeat (3) @(posedge clk);
        #1;
        check_output("init_y_v", y_v, 0);
        check_output("init_y_out", y_out, 0);
        check_output("init_e_rdy", e_rdy, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("init_e_rdy_release", e_rdy, 1);
        in_reset = 1'b0;

        // Zero coefficients: output equals input
        $display("[TB] zero coefficients");
        set_drive(0, 0);
        load_coefs();
        apply_stimulus(1000, 1'b0, 1'b0);
        wait_idle();

        // a1 = -0.5: decaying impulse response
        $display("[TB] a1 = -0.5 decay");
        do_reset();
        set_drive(-16384, 0);
        load_coefs();
        apply_stimulus(16384, 1'b0, 1'b0);
        apply_stimulus(0, 1'b0, 1'b0);
        apply_stimulus(0, 1'b0, 1'b0);
        apply_stimulus(0, 1'b0, 1'b0);
        wait_idle();

        // a1 = -1.0: saturation and rounding of negatives
        $display("[TB] a1 = -1.0 saturation");
        do_reset();
        set_drive(-32768, 0);
        load_coefs();
        apply_stimulus(20000, 1'b0, 1'b0);
        apply_stimulus(20000, 1'b0, 1'b0);
        apply_stimulus(-32768, 1'b0, 1'b0);
        wait_idle();

        // Coefficient update mid-sample goes to the shadow bank, last wins
        $display("[TB] shadow bank update");
        do_reset();
        set_drive(0, 0);
        load_coefs();
        apply_stimulus(100, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        set_drive(12345, 0);
        pulse_busy_coefs();
        @(negedge clk);
        set_drive(-32768, 0);
        pulse_busy_coefs();
        wait_idle();
        apply_stimulus(100, 1'b0, 1'b0);
        wait_idle();

        // Coefficient strobe on the accepting edge applies to that sample
        set_drive(-16384, 0);
        apply_stimulus(0, 1'b0, 1'b1);
        wait_idle();

        // Reset during the 6th MAC cycle aborts the sample
        $display("[TB] reset mid-MAC");
        do_reset();
        set_drive(12000, 3000);
        load_coefs();
        apply_stimulus(500, 1'b0, 1'b0);
        apply_stimulus(-700, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1;
        in_reset = 1'b1;
        rst      = 1'b0;
        model_clear();
        @(negedge clk);
        check_output("midrst_e_rdy", e_rdy, 0);
        @(posedge clk);
        #1;
        check_output("midrst_y_v", y_v, 0);
        check_output("midrst_y_out", y_out, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_output("midrst_e_rdy_release", e_rdy, 1);
        in_reset = 1'b0;
        apply_stimulus(7, 1'b0, 1'b0);
        wait_idle();
        // Every tap at -1.0 with a zero input sums the whole history.
        set_drive(-32768, -32768);
        load_coefs();
        apply_stimulus(0, 1'b0, 1'b0);
        wait_idle();

        // Random coefficient set and samples across all taps
        $display("[TB] random taps");
        do_reset();
        for (int i = 1; i <= TAPS; i++) coef_drive[i] = 16'(int'($urandom_range(12000)) - 6000);
        load_coefs();
        for (int k = 0; k < 6; k++) begin
            apply_stimulus(int'($urandom_range(40000)) - 20000, 1'b0, 1'b0);
        end
        wait_idle();

        // Back-to-back samples with e_v held high
        $display("[TB] sustained throughput");
        do_reset();
        set_drive(-16384, 0);
        coef_drive[2] = 16'sd8192;
        load_coefs();
        apply_stimulus(1000, 1'b1, 1'b0);
        prev_acc = acc_last;
        apply_stimulus(-2000, 1'b1, 1'b0);
        check_output("accept_spacing", acc_last - prev_acc, 12);
        prev_acc = acc_last;
        apply_stimulus(3000, 1'b1, 1'b0);
        check_output("accept_spacing", acc_last - prev_acc, 12);
        prev_acc = acc_last;
        apply_stimulus(-4000, 1'b1, 1'b0);
        check_output("accept_spacing", acc_last - prev_acc, 12);
        prev_acc = acc_last;
        apply_stimulus(5000, 1'b0, 1'b0);
        check_output("accept_spacing", acc_last - prev_acc, 12);
        wait_idle();
        repeat (15) @(negedge clk);

        check_output("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lpc_synth.md
LPC_SYNTH -- requirements
Module: lpc_synth

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous and active-low (0 = reset).
REQ-003 SHALL have ports: a_in1..a_in10  input  16 each  signed Q15 predictor coefficients a_i, driven from the coefficient-update stage outputs.
REQ-004 SHALL have port: a_v  input  1  one-cycle strobe marking a_in1..a_in10 valid.
REQ-005 SHALL have port: e_in  input  16  signed residual (excitation) sample.
REQ-006 SHALL have port: e_v  input  1  e_in valid.
REQ-007 SHALL have port: e_rdy  output  1  block can accept a sample; the transfer occurs on an edge where e_v and e_rdy are both 1.
REQ-008 SHALL have port: y_out  output  16  signed synthesized speech sample.
REQ-009 SHALL have port: y_v  output  1  one-cycle strobe marking y_out valid.
REQ-010 SHALL have constants: ORDER, default 10, filter order; QF, default 15, coefficient fraction bits; ACC_W, default 40, accumulator width.

Function
REQ-011 SHALL compute the all-pole synthesis y[n] = e[n] - sum(i=1..10) a_i*y[n-i], which inverts the analysis filter A(z)=1+sum a_i z^-i.
REQ-012 SHALL implement a FSM with states IDLE, MAC and OUT; e_rdy = 1 only in IDLE.
REQ-013 IDLE->MAC on sample transfer: acc <= (e_in <<< 15) + 0x4000 (round-half-up), tap counter <= 1.
REQ-014 MAC: per cycle acc <= acc - a_i*y_hist[i], i = counter; counter increments; after i = 10, go to OUT (exactly 10 MAC cycles).
REQ-015 Products SHALL be full 32-bit signed; acc SHALL be 40-bit signed and never wrap internally.
REQ-016 OUT: r = acc >>> 15; saturate r to [-32768, 32767]; y_out <= r; y_v <= 1; history shifts (y_hist[10..2] <= y_hist[9..1], y_hist[1] <= saturated r); go to IDLE.
REQ-017 y_v SHALL assert exactly 12 rising edges after the accepting edge, for one cycle; e_rdy SHALL be 1 in that same cycle; sustained throughput is 1 sample per 12 cycles.
REQ-018 y_out SHALL hold its last value between strobes.
REQ-019 a_v in IDLE: working bank SHALL load on that edge.
REQ-020 a_v and an accepted sample on the same edge: that sample SHALL use the new coefficients.
REQ-021 a_v in MAC or OUT: coefficients SHALL latch into a shadow bank with a pending flag; the current sample SHALL finish with the old bank; the shadow SHALL copy to the working bank on the OUT->IDLE edge.
REQ-022 A second a_v while pending SHALL overwrite the shadow bank (last wins).
REQ-023 e_v while e_rdy = 0 SHALL be ignored; the sample is not consumed, and the source must hold it.

Reset
REQ-024 While rst = 0: state = IDLE, acc = 0, counter = 0, y_hist[1..10] = 0, working and shadow banks = 0, pending = 0, y_out = 0, y_v = 0, e_rdy = 0.
REQ-025 Reset asserted mid-MAC or mid-OUT SHALL abort the sample with no y_v and clear history.
REQ-026 e_rdy SHALL be 1 in the first cycle after rst returns to 1.

Structure
REQ-027 Package lpc_pkg SHALL hold ORDER, QF, ACC_W, the sample/coefficient width (16), the rounding constant 0x4000, saturation limits and the FSM state type.
REQ-028 One sub-module lpc_mac (combinational: acc_in, coef, sample -> acc_in - coef*sample at ACC_W) SHALL be instantiated once and shared across taps.
REQ-029 Coefficient and history storage SHALL be register arrays indexed by the tap counter; no RAM.

Verification
REQ-030 All coefficients 0, a_v pulse; e_in = 1000 -> y_out = 1000, y_v exactly 12 edges after the accept.
REQ-031 a_in1 = -16384 (-0.5), others 0; samples 16384, 0, 0, 0 -> y_out = 16384, 8192, 4096, 2048.
REQ-032 a_in1 = -32768 (-1.0), others 0; samples 20000, 20000, -32768 -> y_out = 20000, 32767 (saturated), -1.
REQ-033 a_in1 = 0 loaded; start sample e = 100; at the 5th MAC cycle pulse a_v with a_in1 = -32768; send e = 100 again -> outputs 100, then 200 (new bank applied only to the second sample).
REQ-034 Assert rst at the 6th MAC cycle -> no y_v; after release e_rdy = 1 next cycle; with all-zero coefficients, e = 7 -> y_out = 7 and history is all zero.
REQ-035 e_v held 1 for 5 samples -> exactly 5 y_v pulses spaced 12 cycles apart; e_rdy = 0 throughout each MAC/OUT.
